// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: drives the word address, registers the returned
// MIPS word, decodes its fields and delivers it downstream with valid/ready.
module instr_fetch_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [7:0]  mem_addr,
  input  logic [31:0] mem_rd,
  input  logic        redirect,
  input  logic [7:0]  redirect_addr,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [7:0]  pc_out,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [31:0] imm32,
  output logic        is_rtype,
  output logic        is_addi,
  output logic        is_illegal,
  output logic        halted,
  output logic [15:0] instr_count
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t     state;
  logic [7:0] pc;
  logic       fetch;
  logic       accept;

  // A fetch needs a free (or draining) output slot; en=0 stops fetching at once.
  assign fetch  = (state == RUN) && en && (!out_valid || out_ready) && !redirect;
  assign accept = out_valid && out_ready && !redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= 8'h00;
      out_valid   <= 1'b0;
      instr       <= 32'h0;
      pc_out      <= 8'h00;
      instr_count <= 16'h0;
    end else begin
      if (accept && (instr_count != 16'hFFFF))
        instr_count <= instr_count + 16'h1;

      if (redirect) begin
        pc        <= redirect_addr;
        out_valid <= 1'b0;
        state     <= RUN;
      end else begin
        case (state)
          IDLE:    if (en) state <= RUN;
          RUN:     if (!en) state <= IDLE;
          default: state <= HALT;
        endcase

        // An all-zero word halts the unit without being delivered.
        if (fetch) begin
          if (mem_rd == 32'h0) begin
            state     <= HALT;
            out_valid <= 1'b0;
          end else begin
            instr     <= mem_rd;
            pc_out    <= pc;
            out_valid <= 1'b1;
            pc        <= pc + 8'h01;
          end
        end else if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  assign mem_addr   = pc;
  assign halted     = (state == HALT);
  assign opcode     = instr[31:26];
  assign rs         = instr[25:21];
  assign rt         = instr[20:16];
  assign rd         = instr[15:11];
  assign shamt      = instr[10:6];
  assign funct      = instr[5:0];
  assign imm32      = {{16{instr[15]}}, instr[15:0]};
  assign is_rtype   = (opcode == 6'b000000);
  assign is_addi    = (opcode == 6'b001000);
  assign is_illegal = out_valid && !is_rtype && !is_addi;

endmodule
